// File: rtl/sdram_read_scheduler_if.sv
// Bundle of command, SDRAM read-port and FIFO write-port signals for the read scheduler.
// slave is the scheduler's view; master is the surrounding system (controller, FIFO, host).
interface sdram_read_scheduler_if #(
  parameter int ADDR_W  = 25,
  parameter int LEN_W   = 16,
  parameter int USEDW_W = 6
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              abort;
  logic              busy;
  logic              done;
  logic              err;
  logic              sd_rd_req;
  logic [ADDR_W-1:0] sd_rd_addr;
  logic [4:0]        sd_rd_len;
  logic              sd_rd_ack;
  logic              sd_rd_valid;
  logic [15:0]       sd_rd_data;
  logic [15:0]       fifo_data;
  logic              fifo_wrreq;
  logic [USEDW_W-1:0] fifo_wrusedw;
  logic              fifo_wrfull;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, abort, sd_rd_ack, sd_rd_valid, sd_rd_data,
           fifo_wrusedw, fifo_wrfull,
    output cmd_ready, busy, done, err, sd_rd_req, sd_rd_addr, sd_rd_len, fifo_data, fifo_wrreq
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_len, abort, sd_rd_ack, sd_rd_valid, sd_rd_data,
           fifo_wrusedw, fifo_wrfull,
    input  cmd_ready, busy, done, err, sd_rd_req, sd_rd_addr, sd_rd_len, fifo_data, fifo_wrreq
  );
endinterface

// File: rtl/sdram_read_scheduler.sv
// Splits a linear read command into SDRAM bursts, issuing each only when the read-return
// FIFO is guaranteed to hold it plus everything in flight; forwards returned words.
module sdram_read_scheduler #(
  parameter int ADDR_W      = 25,
  parameter int LEN_W       = 16,
  parameter int BURST_LEN   = 8,
  parameter int FIFO_DEPTH  = 64,
  parameter int USEDW_W     = 6,
  parameter int FIFO_MARGIN = 2
) (
  input logic clk,
  input logic aclr,
  sdram_read_scheduler_if.slave bus
);
  localparam int UE_W  = USEDW_W + 1;
  localparam int SUM_W = 9;

  typedef enum logic [2:0] {IDLE, CHECK, REQ, DRAIN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [LEN_W-1:0]  remaining_reg;
  logic [6:0]        inflight_reg;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic [4:0]        rd_len_reg;
  logic              done_reg, err_reg, wrreq_reg;
  logic [15:0]       data_reg;

  logic [UE_W-1:0]   used_eff;
  logic [4:0]        blen;
  logic [SUM_W-1:0]  need;
  logic              fits, ack_taken, load_cmd, issue;
  logic [6:0]        inflight_inc, inflight_dec;

  // wrusedw wraps to 0 when the FIFO is completely full, so wrfull overrides it
  assign used_eff  = bus.fifo_wrfull ? UE_W'(FIFO_DEPTH) : {1'b0, bus.fifo_wrusedw};
  assign blen      = (remaining_reg >= LEN_W'(BURST_LEN)) ? 5'(BURST_LEN) : remaining_reg[4:0];
  assign need      = SUM_W'(used_eff) + SUM_W'(inflight_reg) + SUM_W'(blen);
  assign fits      = need <= SUM_W'(FIFO_DEPTH - FIFO_MARGIN);
  assign ack_taken = (state_reg == REQ) && bus.sd_rd_ack;

  always_comb begin
    state_next = state_reg;
    load_cmd   = 1'b0;
    issue      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.cmd_valid) begin
          load_cmd   = 1'b1;
          state_next = (bus.cmd_len == '0) ? DONE : CHECK;
        end
      end
      CHECK: begin
        if (bus.abort || remaining_reg == '0) begin
          state_next = DRAIN;
        end else if (fits) begin
          issue      = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        // the request is never retracted: abort only matters once it is accepted
        if (bus.sd_rd_ack) state_next = bus.abort ? DRAIN : CHECK;
      end
      DRAIN:   if (inflight_reg == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // a return with nothing outstanding is flagged but never drives the counter negative
  assign inflight_inc = ack_taken ? {2'b00, rd_len_reg} : 7'd0;
  assign inflight_dec = (bus.sd_rd_valid && inflight_reg != '0) ? 7'd1 : 7'd0;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      addr_reg      <= '0;
      remaining_reg <= '0;
      inflight_reg  <= '0;
      rd_addr_reg   <= '0;
      rd_len_reg    <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      wrreq_reg     <= 1'b0;
      data_reg      <= '0;
    end else begin
      if (load_cmd) begin
        addr_reg      <= bus.cmd_addr;
        remaining_reg <= bus.cmd_len;
      end else if (ack_taken) begin
        addr_reg      <= addr_reg + ADDR_W'(rd_len_reg);
        remaining_reg <= remaining_reg - LEN_W'(rd_len_reg);
      end
      if (issue) begin
        rd_addr_reg <= addr_reg;
        rd_len_reg  <= blen;
      end
      inflight_reg <= inflight_reg + inflight_inc - inflight_dec;
      done_reg     <= (state_reg == DONE);
      if (bus.sd_rd_valid && (bus.fifo_wrfull || inflight_reg == '0)) err_reg <= 1'b1;
      wrreq_reg <= bus.sd_rd_valid && !bus.fifo_wrfull;
      if (bus.sd_rd_valid) data_reg <= bus.sd_rd_data;
    end
  end

  assign bus.cmd_ready  = (state_reg == IDLE);
  assign bus.busy       = (state_reg != IDLE);
  assign bus.done       = done_reg;
  assign bus.err        = err_reg;
  assign bus.sd_rd_req  = (state_reg == REQ);
  assign bus.sd_rd_addr = rd_addr_reg;
  assign bus.sd_rd_len  = rd_len_reg;
  assign bus.fifo_wrreq = wrreq_reg;
  assign bus.fifo_data  = data_reg;
endmodule

// File: tb/tb_sdram_read_scheduler.sv
// Scoreboard bench for sdram_read_scheduler: expected bursts/words are queued at issue time
// and a negedge monitor pops and compares them as the DUT presents requests and FIFO writes.
module tb_sdram_read_scheduler;
  localparam int ADDR_W = 25, LEN_W = 16, USEDW_W = 6;
  localparam int BIG = 1 << 30;

  logic clk = 1'b0;
  logic aclr = 1'b0;
  always #5 clk = ~clk;

  sdram_read_scheduler_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .USEDW_W(USEDW_W)) bus ();

  sdram_read_scheduler #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BURST_LEN(8), .FIFO_DEPTH(64),
    .USEDW_W(USEDW_W), .FIFO_MARGIN(2)
  ) dut (
    .clk(clk),
    .aclr(aclr),
    .bus(bus)
  );

  int total = 0, bad = 0;
  logic [15:0]       ret_q[$];
  logic [15:0]       exp_word[$];
  logic [ADDR_W+4:0] exp_req[$];
  int ack_delay = 0, ack_wait = 0, ret_budget = BIG;
  bit auto_ack = 1'b1, man_ack = 1'b0, rd_en = 1'b1;
  int fcount = 0, fmax = 0, wr_seen = 0, done_cnt = 0;
  logic prev_vnf = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  task automatic exp_burst(input logic [ADDR_W-1:0] a, input int len);
    exp_req.push_back({a, 5'(len)});
    for (int i = 0; i < len; i++) exp_word.push_back(word_of(a + ADDR_W'(i)));
  endtask

  // one clock of the SDRAM controller and FIFO models, driven just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.fifo_wrreq) begin fcount++; wr_seen++; end
    if (rd_en && fcount > 0) fcount--;
    if (fcount > fmax) fmax = fcount;
    bus.fifo_wrusedw = fcount[5:0];
    bus.fifo_wrfull  = (fcount >= 64);
    // returns are served before acks so a burst's words never share its own ack cycle
    if (ret_budget > 0 && ret_q.size() > 0) begin
      bus.sd_rd_valid = 1'b1;
      bus.sd_rd_data  = ret_q.pop_front();
      ret_budget--;
    end else begin
      bus.sd_rd_valid = 1'b0;
    end
    if (bus.sd_rd_ack) begin
      bus.sd_rd_ack = 1'b0;
    end else if (bus.sd_rd_req && (auto_ack ? (ack_wait >= ack_delay) : man_ack)) begin
      bus.sd_rd_ack = 1'b1;
      ack_wait = 0;
      for (int i = 0; i < int'(bus.sd_rd_len); i++)
        ret_q.push_back(word_of(bus.sd_rd_addr + ADDR_W'(i)));
    end else if (bus.sd_rd_req) begin
      ack_wait++;
    end
  endtask

  task automatic issue_cmd(input logic [ADDR_W-1:0] a, input int len);
    int n = 0;
    while (!bus.cmd_ready && n < 200) begin tick(); n++; end
    chk("cmd_ready_wait", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = LEN_W'(len);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin tick(); n++; end
    chk(name, bus.done, 1);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!bus.sd_rd_req && n < 100) begin tick(); n++; end
    chk(name, bus.sd_rd_req, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_sd_rd_req"}, bus.sd_rd_req, 0);
    chk({tag, "_sd_rd_addr"}, bus.sd_rd_addr, 0);
    chk({tag, "_sd_rd_len"}, bus.sd_rd_len, 0);
    chk({tag, "_fifo_wrreq"}, bus.fifo_wrreq, 0);
    chk({tag, "_fifo_data"}, bus.fifo_data, 0);
  endtask

  task automatic reset_mid(input string tag);
    @(posedge clk);
    #2;
    aclr = 1'b1;
    bus.sd_rd_ack = 1'b0;
    bus.sd_rd_valid = 1'b0;
    ret_q.delete();
    exp_req.delete();
    exp_word.delete();
    ack_wait = 0;
    auto_ack = 1'b1;
    ret_budget = BIG;
    fcount = 0;
    #1;
    check_reset_outputs(tag);
    tick();
    tick();
    aclr = 1'b0;
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a FIFO write or an accepted request
  initial forever begin
    @(negedge clk);
    if (aclr) begin
      prev_vnf = 1'b0;
    end else begin
      if (prev_vnf || bus.fifo_wrreq) chk("wrreq_latency", bus.fifo_wrreq, prev_vnf);
      if (bus.fifo_wrreq) begin
        if (exp_word.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_word: got=%0h expected=none", bus.fifo_data);
        end else begin
          chk("fifo_word", bus.fifo_data, exp_word.pop_front());
        end
      end
      prev_vnf = bus.sd_rd_valid && !bus.fifo_wrfull;
      if (bus.sd_rd_req && bus.sd_rd_ack) begin
        if (exp_req.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_req: got addr=%0h len=%0d expected=none", bus.sd_rd_addr, bus.sd_rd_len);
        end else begin
          chk("burst_req", {bus.sd_rd_addr, bus.sd_rd_len}, exp_req.pop_front());
        end
      end
      if (bus.done) done_cnt++;
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int ws;
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.abort = 1'b0;
    bus.sd_rd_ack = 1'b0; bus.sd_rd_valid = 1'b0; bus.sd_rd_data = '0;
    bus.fifo_wrusedw = '0; bus.fifo_wrfull = 1'b0;
    #1 aclr = 1'b1;
    #2 check_reset_outputs("rst");
    tick(); tick();
    aclr = 1'b0;
    tick();

    // basic split: 20 words from 0x100 -> 8, 8, 4
    done_cnt = 0; ack_delay = 1;
    exp_burst(25'h100, 8); exp_burst(25'h108, 8); exp_burst(25'h110, 4);
    issue_cmd(25'h100, 20);
    wait_done("t1_done", 500);
    repeat (4) tick();
    chk("t1_done_count", done_cnt, 1);
    chk("t1_req_left", exp_req.size(), 0);
    chk("t1_word_left", exp_word.size(), 0);
    chk("t1_err", bus.err, 0);

    // stalled reader: 7 bursts fit (56 words), the 8th would reach 64 > 62
    done_cnt = 0; ack_delay = 0; rd_en = 1'b0; fmax = 0;
    for (int k = 0; k < 12; k++) exp_burst(25'h2000 + 25'(8 * k), 8);
    exp_burst(25'h2060, 4);
    issue_cmd(25'h2000, 100);
    repeat (300) tick();
    chk("t2_stall_fill", fcount, 56);
    chk("t2_stall_busy", bus.busy, 1);
    chk("t2_stall_req", bus.sd_rd_req, 0);
    rd_en = 1'b1;
    wait_done("t2_done", 3000);
    repeat (4) tick();
    chk("t2_peak_fill", fmax, 56);
    chk("t2_done_count", done_cnt, 1);
    chk("t2_word_left", exp_word.size(), 0);
    chk("t2_err", bus.err, 0);

    // ack and return in the same cycle: inflight 5 + 8 - 1 = 12
    done_cnt = 0; auto_ack = 1'b0; man_ack = 1'b0; ret_budget = 0;
    exp_burst(25'h300, 8); exp_burst(25'h308, 8);
    issue_cmd(25'h300, 16);
    wait_req("t3_req1");
    man_ack = 1'b1; tick(); man_ack = 1'b0;
    ret_budget = 3;
    repeat (4) tick();
    chk("t3_inflight_before", dut.inflight_reg, 5);
    wait_req("t3_req2");
    man_ack = 1'b1; ret_budget = 1; tick(); man_ack = 1'b0;
    tick();
    chk("t3_inflight_after", dut.inflight_reg, 12);
    auto_ack = 1'b1; ret_budget = BIG;
    wait_done("t3_done", 500);
    repeat (4) tick();
    chk("t3_done_count", done_cnt, 1);
    chk("t3_word_left", exp_word.size(), 0);

    // abort while requesting: only the pending burst completes
    done_cnt = 0; ack_delay = 3;
    exp_burst(25'h400, 8);
    issue_cmd(25'h400, 40);
    wait_req("t4_req");
    bus.abort = 1'b1;
    wait_done("t4_done", 500);
    bus.abort = 1'b0;
    repeat (10) tick();
    chk("t4_done_count", done_cnt, 1);
    chk("t4_req_left", exp_req.size(), 0);
    chk("t4_word_left", exp_word.size(), 0);
    chk("t4_idle", bus.cmd_ready, 1);

    // spurious return while idle: forwarded, err set and sticky
    ret_q.push_back(16'hBEEF); exp_word.push_back(16'hBEEF);
    repeat (4) tick();
    chk("t5_spurious_err", bus.err, 1);
    chk("t5_spurious_fwd", exp_word.size(), 0);
    repeat (5) tick();
    chk("t5_err_sticky", bus.err, 1);

    // return while FIFO full (burst outstanding): write dropped, err set
    reset_mid("t6_rst");
    done_cnt = 0; auto_ack = 1'b0; ret_budget = 0;
    exp_req.push_back({25'h600, 5'd8});
    for (int i = 1; i < 8; i++) exp_word.push_back(word_of(25'h600 + 25'(i)));
    issue_cmd(25'h600, 8);
    wait_req("t6_req");
    man_ack = 1'b1; tick(); man_ack = 1'b0;
    tick();
    chk("t6_err_before", bus.err, 0);
    rd_en = 1'b0; fcount = 64; ws = wr_seen; ret_budget = 1;
    repeat (3) tick();
    chk("t6_full_err", bus.err, 1);
    chk("t6_full_nowrite", wr_seen - ws, 0);
    fcount = 0; rd_en = 1'b1; auto_ack = 1'b1; ret_budget = BIG;
    wait_done("t6_done", 500);
    repeat (3) tick();
    chk("t6_word_left", exp_word.size(), 0);
    chk("t6_err_sticky", bus.err, 1);

    // reset mid-burst, then a zero-length command
    exp_burst(25'h500, 8); exp_burst(25'h508, 8); exp_burst(25'h510, 4);
    ack_delay = 1; ws = wr_seen;
    issue_cmd(25'h500, 20);
    for (int n = 0; n < 200 && (wr_seen - ws) < 3; n++) tick();
    chk("t7_words_before_rst", (wr_seen - ws) >= 3, 1);
    reset_mid("t7_rst");
    done_cnt = 0;
    issue_cmd(25'h0, 0);
    chk("t7_len0_busy", bus.busy, 1);
    chk("t7_len0_done_early", bus.done, 0);
    chk("t7_len0_req1", bus.sd_rd_req, 0);
    tick();
    chk("t7_len0_done", bus.done, 1);
    chk("t7_len0_req2", bus.sd_rd_req, 0);
    repeat (3) tick();
    chk("t7_len0_done_count", done_cnt, 1);
    chk("t7_len0_idle", bus.cmd_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
